// File: rtl/uart_merge_pkg.sv
// Constants shared by the UART merge FIFO and the IO read mux.
package uart_merge_pkg;

    localparam int DW            = 8;
    localparam int UART_BUSY_BIT = 9;

endpackage

// File: rtl/sync_fifo_2w1r.sv
// Synchronous FIFO with two ordered write ports and one read port.
// Port 1 writes only alongside port 0 and lands one slot after it.
module sync_fifo_2w1r #(
    parameter  int DEPTH = 16,
    parameter  int DW    = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  logic [DW-1:0] wr0_data,
    input  logic          wr1_en,
    input  logic [DW-1:0] wr1_data,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   wr1_ptr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr1_ptr  = wr_ptr_q + 1'b1;
        if (wr0_en) begin
            wr_ptr_d = wr1_en ? wr_ptr_q + (AW+1)'(2) : wr1_ptr;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; writes during reset are suppressed so contents stay discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr0_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wr0_data;
            end
            if (wr0_en && wr1_en) begin
                mem_q[wr1_ptr[AW-1:0]] <= wr1_data;
            end
        end
    end

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        rd_valid = (level != '0);
        rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

endmodule

// File: rtl/uart_tx_merge_fifo.sv
// Merges the two CPU IO write lanes into one ordered byte stream for the UART.
// Lane a is always enqueued ahead of lane b; bytes that do not fit are dropped.
module uart_tx_merge_fifo
    import uart_merge_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int DW    = uart_merge_pkg::DW,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_a_valid,
    input  logic [DW-1:0] i_a_data,
    input  logic          i_b_valid,
    input  logic [DW-1:0] i_b_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    output logic          o_busy,
    output logic [AW:0]   o_level,
    output logic          o_overflow
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO      = (AW+1)'(2);

    logic [AW:0]   free;
    logic          wr0_en, wr1_en, drop;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          overflow_q, overflow_d;

    // Free space comes from registered occupancy only; a same-cycle pop does not help.
    always_comb begin
        free     = FULL_LVL - o_level;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = i_a_data;
        wr1_data = i_b_data;
        drop     = 1'b0;
        if (i_a_valid && i_b_valid) begin
            if (free >= TWO) begin
                wr0_en = 1'b1;
                wr1_en = 1'b1;
            end else if (free != '0) begin
                wr0_en = 1'b1;
                drop   = 1'b1;
            end else begin
                drop   = 1'b1;
            end
        end else if (i_a_valid || i_b_valid) begin
            wr0_data = i_a_valid ? i_a_data : i_b_data;
            if (free != '0) begin
                wr0_en = 1'b1;
            end else begin
                drop   = 1'b1;
            end
        end
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    sync_fifo_2w1r #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (o_valid & i_ready),
        .rd_valid (o_valid),
        .rd_data  (o_data),
        .level    (o_level)
    );

    assign o_busy     = (free < TWO);
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_merge_fifo.sv
// Scoreboard bench for uart_tx_merge_fifo: directed scenarios followed by random traffic.
module tb_uart_tx_merge_fifo;

    localparam int DEPTH = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_a_valid = 1'b0, i_b_valid = 1'b0, i_ready = 1'b0;
    logic [7:0] i_a_data = 8'h00, i_b_data = 8'h00;
    logic       o_valid, o_busy, o_overflow;
    logic [7:0] o_data;
    logic [4:0] o_level;

    int checks = 0;
    int errors = 0;

    // Reference state: expected byte stream plus occupancy and sticky flag.
    logic [7:0] exp_q[$];
    int         mdl_level = 0;
    bit         mdl_ovf = 1'b0;
    bit         mon_en = 1'b0;
    logic [7:0] last_rx = 8'h00;
    int         rx_cnt = 0;

    uart_tx_merge_fifo #(.DEPTH(DEPTH), .DW(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_a_valid  (i_a_valid),
        .i_a_data   (i_a_data),
        .i_b_valid  (i_b_valid),
        .i_b_data   (i_b_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the push/drop/pop rules once per clock edge.
    always @(posedge i_clk) begin
        if (i_rst) begin
            exp_q.delete();
            mdl_level = 0;
            mdl_ovf   = 1'b0;
        end else begin
            int free, pushes, pops;
            free   = DEPTH - mdl_level;
            pops   = (mdl_level > 0 && i_ready) ? 1 : 0;
            pushes = 0;
            if (i_a_valid && i_b_valid) begin
                if (free >= 2) begin
                    exp_q.push_back(i_a_data);
                    exp_q.push_back(i_b_data);
                    pushes = 2;
                end else if (free == 1) begin
                    exp_q.push_back(i_a_data);
                    pushes  = 1;
                    mdl_ovf = 1'b1;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end else if (i_a_valid || i_b_valid) begin
                if (free >= 1) begin
                    exp_q.push_back(i_a_valid ? i_a_data : i_b_data);
                    pushes = 1;
                end else begin
                    mdl_ovf = 1'b1;
                end
            end
            mdl_level = mdl_level + pushes - pops;
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each UART handshake.
    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("level", int'(o_level), mdl_level);
            chk("valid", int'(o_valid), int'(mdl_level != 0));
            chk("busy", int'(o_busy), int'(mdl_level >= DEPTH - 1));
            chk("overflow", int'(o_overflow), int'(mdl_ovf));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 0, 1);
                end else begin
                    chk("head_data", int'(o_data), int'(exp_q[0]));
                    if (i_ready && !i_rst) begin
                        last_rx = exp_q.pop_front();
                        rx_cnt++;
                    end
                end
            end else begin
                chk("idle_data", int'(o_data), 0);
            end
        end
    end

    task automatic step(input logic av, input logic [7:0] ad, input logic bv,
                        input logic [7:0] bd, input logic rdy, input logic rst = 1'b0);
        i_a_valid = av; i_a_data = ad;
        i_b_valid = bv; i_b_data = bd;
        i_ready   = rdy; i_rst   = rst;
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (o_level != 0 && n < 4 * DEPTH) begin
            step(0, 8'h00, 0, 8'h00, 1);
            n++;
        end
        chk("drain_done", int'(o_level), 0);
    endtask

    initial begin
        int base;
        step(0, 8'h00, 0, 8'h00, 0, 1);
        mon_en = 1'b1;
        chk("rst_level", int'(o_level), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ovf", int'(o_overflow), 0);

        // Single write visible after one edge, then popped.
        step(1, 8'h41, 0, 8'h00, 0);
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_data", int'(o_data), 8'h41);
        chk("t1_level", int'(o_level), 1);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("t1_level_after", int'(o_level), 0);
        chk("t1_valid_after", int'(o_valid), 0);
        chk("t1_data_after", int'(o_data), 0);

        // Same-cycle dual write keeps a ahead of b.
        step(1, 8'h48, 1, 8'h49, 0);
        chk("t2_level", int'(o_level), 2);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("t2_first", int'(last_rx), 8'h48);
        step(0, 8'h00, 0, 8'h00, 1);
        chk("t2_second", int'(last_rx), 8'h49);

        // Fill to full, then a b-only write is dropped.
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(2 * i), 1, 8'(2 * i + 1), 0);
            if (i == 6) chk("t3_busy14", int'(o_busy), 0);
        end
        chk("t3_level_full", int'(o_level), 16);
        chk("t3_busy_full", int'(o_busy), 1);
        step(0, 8'h00, 1, 8'h55, 0);
        chk("t3_ovf", int'(o_overflow), 1);
        chk("t3_level_hold", int'(o_level), 16);
        base = rx_cnt;
        drain();
        chk("t3_drained", rx_cnt - base, 16);
        chk("t3_last", int'(last_rx), 8'h0F);

        // Level 15 with a dual write: a fits, b drops.
        step(0, 8'h00, 0, 8'h00, 0, 1);
        for (int i = 0; i < 7; i++) step(1, 8'(8'h60 + 2 * i), 1, 8'(8'h61 + 2 * i), 0);
        step(1, 8'h6E, 0, 8'h00, 0);
        chk("t4_level15", int'(o_level), 15);
        chk("t4_busy15", int'(o_busy), 1);
        step(1, 8'h10, 1, 8'h11, 0);
        chk("t4_level", int'(o_level), 16);
        chk("t4_ovf", int'(o_overflow), 1);
        drain();
        chk("t4_last", int'(last_rx), 8'h10);

        // Push and pop together, then a streamed run that wraps the pointers.
        step(0, 8'h00, 0, 8'h00, 0, 1);
        step(1, 8'h21, 0, 8'h00, 0);
        step(1, 8'h22, 0, 8'h00, 1);
        chk("t5_level", int'(o_level), 1);
        chk("t5_head", int'(o_data), 8'h22);
        drain();
        base = rx_cnt;
        for (int i = 0; i < 80; i++) begin
            step(i[0] == 1'b0, 8'(8'h80 + i / 2), 0, 8'h00, i[0]);
        end
        drain();
        chk("t5_stream_cnt", rx_cnt - base, 40);
        chk("t5_stream_last", int'(last_rx), 8'h80 + 39);
        chk("t5_no_ovf", int'(o_overflow), 0);

        // Reset with contents and overflow set, with a write in the same cycle.
        for (int i = 0; i < 8; i++) step(1, 8'(i), 1, 8'(i + 8), 0);
        step(0, 8'h00, 1, 8'h55, 0);
        for (int i = 0; i < 11; i++) step(0, 8'h00, 0, 8'h00, 1);
        chk("t6_level5", int'(o_level), 5);
        chk("t6_ovf_set", int'(o_overflow), 1);
        step(1, 8'h99, 0, 8'h00, 1, 1);
        chk("t6_level", int'(o_level), 0);
        chk("t6_valid", int'(o_valid), 0);
        chk("t6_ovf", int'(o_overflow), 0);
        chk("t6_busy", int'(o_busy), 0);
        step(1, 8'h7E, 0, 8'h00, 0);
        chk("t6_readback", int'(o_data), 8'h7E);
        drain();
        chk("t6_last", int'(last_rx), 8'h7E);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                 8'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
        end
        drain();
        chk("final_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_merge_fifo.md
# uart_tx_merge_fifo

Merges the two CPU IO write lanes (lane a = older instruction, lane b = younger) into one ordered byte stream for the UART emitter, replacing the direct OR of the two lane valids. Bytes are buffered in a small FIFO so that same-cycle writes from both lanes are neither lost nor reordered. The block provides a busy flag for the IO status word and a sticky overflow flag. It sits between the dual-issue core's IO ports and `corescore_emitter_uart`.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `DW`, 8: data width in bits; fixed to 8 for the UART.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_a_valid`  in  1  lane a byte write strobe; equals IO write AND UART word select.
- `i_a_data`  in  DW  lane a byte.
- `i_b_valid`  in  1  lane b byte write strobe.
- `i_b_data`  in  DW  lane b byte.
- `o_valid`  out  1  FIFO head valid; drives UART `i_valid`.
- `o_data`  out  DW  FIFO head byte; drives UART `i_data`.
- `i_ready`  in  1  from UART `o_ready`.
- `o_busy`  out  1  fewer than 2 free entries; software polls this via IO status bit 9.
- `o_level`  out  log2(DEPTH)+1  current occupancy.
- `o_overflow`  out  1  sticky: at least one byte has been dropped since reset.

## Operation
- One clock (`i_clk`); reset is synchronous and active-high (`i_rst`).
- Storage: DEPTH x DW array, with write and read pointers of log2(DEPTH)+1 bits. Pointers wrap naturally. `o_level = wr_ptr - rd_ptr`.
- Free space for the current cycle is `free = DEPTH - o_level`, computed from registered state. A pop in the same cycle does not free space for that cycle's pushes.
- Push rules, in this order of priority:
  - Both valid, free >= 2: write a at wr_ptr, b at wr_ptr+1; wr_ptr += 2.
  - Both valid, free == 1: write a only; drop b; set o_overflow.
  - Both valid, free == 0: drop both; set o_overflow.
  - Single valid (a or b), free >= 1: write it; wr_ptr += 1. Free == 0: drop it; set o_overflow.
- Ordering: a is always enqueued before b from the same cycle. Across cycles, FIFO order holds.
- Pop: when `o_valid & i_ready`, rd_ptr += 1.
- Output signals:
  - `o_valid = (o_level != 0)`.
  - `o_data = mem[rd_ptr]` when o_valid; otherwise 8'h00.
- `o_busy = (free < 2)`, i.e. o_level >= DEPTH-1.
- `o_overflow` is cleared only by reset.
- Reset values: pointers 0, o_level 0, o_valid 0, o_data 8'h00, o_busy 0, o_overflow 0. The storage array is not reset.
- Reset during operation: all contents are discarded. A push or pop in the same cycle as reset is ignored.

## Timing
- Write to visible at head: 1 cycle. A byte pushed at edge N is on o_data with o_valid high after edge N, provided the FIFO was empty.
- No combinational path from i_a_valid or i_b_valid to any output. `o_valid`, `o_busy` and `o_level` are functions of registered state only.
- `i_ready` affects only the next rd_ptr; it does not combinationally affect any output.
- Push and pop in the same cycle: o_level changes by (pushes - 1).
  - Example: single push plus pop leaves o_level unchanged.
  - Example: dual push plus pop increases o_level by 1.
- o_data must be held stable while `o_valid & !i_ready`, which follows from rd_ptr not moving.
- Throughput: up to 2 pushes and 1 pop per cycle.

## Structure
- Package `uart_merge_pkg`: `DW` localparam and the UART status bit index (9) shared with the IO read mux.
- Sub-module `sync_fifo_2w1r`: storage plus pointers, with two ordered write ports, one read port, and level output.
  - The top level holds the free-space and drop logic, o_busy, and the sticky overflow flag.

## Test plan
- Reset, then a-only write 0x41 → the next cycle shows o_valid=1, o_data=0x41, o_level=1. Pulse i_ready → o_level=0, o_valid=0, o_data=0x00.
- Same-cycle a=0x48, b=0x49 with i_ready low → o_level=2. Raise i_ready → UART receives 0x48 then 0x49.
- i_ready low, 8 dual writes (0x00..0x0F) → o_level=16, o_busy=1 from o_level=15. One more b-only write 0x55 → dropped, o_overflow=1, o_level stays 16. Drain → exactly 0x00..0x0F in order.
- o_level=15, dual write a=0x10, b=0x11 → 0x10 accepted, 0x11 dropped, o_overflow=1, o_level=16, and 0x10 is the last byte drained.
- o_level=1, single push 0x22 with i_ready high in the same cycle → o_level stays 1, head becomes 0x22. Stream 40 bytes with i_ready toggling every cycle → all 40 are received in order, pointers wrap, no overflow.
- o_level=5 with o_overflow=1, assert i_rst for one cycle together with a write → o_level=0, o_valid=0, o_overflow=0, o_busy=0. A following write of 0x7E is read back as 0x7E.
